// File: rtl/raster_stamp_agent.sv
// raster_stamp_agent: pulls raster stamps one pid at a time into the raster CSR store, then commits a per-thread stamp-present mask.
// Write beat 1 cycle after each stamp handshake, response after the last write retires; stalls on stamp_valid and rsp_ready.
module raster_stamp_agent #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 4,
  parameter int NW_WIDTH    = 2,
  parameter int UUID_WIDTH  = 44,
  parameter int STAMP_W     = 64,
  parameter int PID_WIDTH   = (NUM_THREADS / NUM_LANES > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [UUID_WIDTH-1:0]        req_uuid,
  input  logic [NW_WIDTH-1:0]          req_wid,
  input  logic [NUM_THREADS-1:0]       req_tmask,
  input  logic                         stamp_valid,
  output logic                         stamp_ready,
  input  logic                         stamp_done,
  input  logic [NUM_LANES-1:0]         stamp_lmask,
  input  logic [NUM_LANES*STAMP_W-1:0] stamp_data,
  output logic                         write_enable,
  output logic [UUID_WIDTH-1:0]        write_uuid,
  output logic [NW_WIDTH-1:0]          write_wid,
  output logic [NUM_LANES-1:0]         write_tmask,
  output logic [PID_WIDTH-1:0]         write_pid,
  output logic [NUM_LANES*STAMP_W-1:0] write_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [UUID_WIDTH-1:0]        rsp_uuid,
  output logic [NW_WIDTH-1:0]          rsp_wid,
  output logic [NUM_THREADS-1:0]       rsp_tmask,
  output logic [NUM_THREADS-1:0]       rsp_data,
  output logic [31:0]                  perf_stamps
);
  localparam int NUM_PIDS = NUM_THREADS / NUM_LANES;
  localparam logic [PID_WIDTH-1:0] LAST_PID = PID_WIDTH'(NUM_PIDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RSP} state_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
  } req_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]        uuid;
    logic [NW_WIDTH-1:0]          wid;
    logic [NUM_LANES-1:0]         tmask;
    logic [PID_WIDTH-1:0]         pid;
    logic [NUM_LANES*STAMP_W-1:0] data;
  } wr_t;

  state_t                 state_q, state_d;
  req_t                   req_q, req_d;
  wr_t                    wr_q, wr_d;
  logic                   wr_vld_q, wr_vld_d;
  logic [PID_WIDTH-1:0]   pid_q, pid_d;
  logic [NUM_THREADS-1:0] result_q, result_d;
  logic                   done_q, done_d;
  logic [31:0]            perf_q, perf_d;

  logic [NUM_LANES-1:0]   active;
  logic [NUM_LANES-1:0]   hit;
  logic                   last_pid;
  logic                   advance;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wr_d     = wr_q;
    wr_vld_d = 1'b0;
    pid_d    = pid_q;
    result_d = result_q;
    done_d   = done_q;
    perf_d   = perf_q;
    advance  = 1'b0;
    active   = req_q.tmask[pid_q*NUM_LANES +: NUM_LANES];
    hit      = active & stamp_lmask;
    last_pid = (pid_q == LAST_PID);

    // A done beat is never consumed, so ready must drop as soon as done shows up.
    stamp_ready = (state_q == FETCH) && (active != '0) && !stamp_done;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.uuid  = req_uuid;
          req_d.wid   = req_wid;
          req_d.tmask = req_tmask;
          pid_d       = '0;
          result_d    = '0;
          done_d      = 1'b0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (active == '0) begin
          advance = 1'b1;
        end else if (stamp_valid && stamp_done) begin
          done_d  = 1'b1;
          state_d = DRAIN;
        end else if (stamp_valid) begin
          wr_vld_d   = 1'b1;
          wr_d.uuid  = req_q.uuid;
          wr_d.wid   = req_q.wid;
          wr_d.tmask = hit;
          wr_d.pid   = pid_q;
          wr_d.data  = stamp_data;
          result_d   = result_q | (NUM_THREADS'(hit) << (pid_q * NUM_LANES));
          advance    = 1'b1;
        end
        if (advance) begin
          if (last_pid) state_d = DRAIN;
          else          pid_d   = pid_q + PID_WIDTH'(1);
        end
      end
      DRAIN:   state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_vld_q) perf_d = perf_q + 32'($countones(wr_q.tmask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      wr_q     <= '0;
      wr_vld_q <= 1'b0;
      pid_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      perf_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      wr_vld_q <= wr_vld_d;
      pid_q    <= pid_d;
      result_q <= result_d;
      done_q   <= done_d;
      perf_q   <= perf_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RSP);
  assign write_enable = wr_vld_q;
  assign write_uuid   = wr_q.uuid;
  assign write_wid    = wr_q.wid;
  assign write_tmask  = wr_q.tmask;
  assign write_pid    = wr_q.pid;
  assign write_data   = wr_q.data;
  assign rsp_uuid     = req_q.uuid;
  assign rsp_wid      = req_q.wid;
  assign rsp_tmask    = req_q.tmask;
  assign rsp_data     = result_q;
  assign perf_stamps  = perf_q;

endmodule

// File: doc/raster_stamp_agent.md
# raster_stamp_agent

Transmit side of the raster CSR path: executes a warp's raster-fetch request by pulling quad stamps from the raster unit, writes them into the per-warp raster CSR store one thread group (pid) at a time over the `write_*` port, then commits a per-thread "stamp present" result to the SFU commit path. It sits in the SFU between the dispatch of the raster-fetch instruction, the raster unit's stamp output, and the raster CSR store.

## Interface
- NUM_THREADS, 4, threads per warp
- NUM_LANES, 4, lanes per CSR write beat; NUM_THREADS % NUM_LANES == 0; NUM_PIDS = NUM_THREADS/NUM_LANES
- PID_WIDTH, LOG2UP(NUM_PIDS), pid index width
- NW_WIDTH, 2, warp id width
- UUID_WIDTH, 44, instruction uuid width
- STAMP_W, 64, bit width of one raster_stamp_t
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in/out  1  fetch request handshake
- req_uuid  in  UUID_WIDTH;  req_wid  in  NW_WIDTH;  req_tmask  in  NUM_THREADS
- stamp_valid / stamp_ready  in/out  1  stamp beat handshake
- stamp_done  in  1  raster exhausted; beat carries no stamps and is never consumed
- stamp_lmask  in  NUM_LANES  lanes of the beat holding a stamp
- stamp_data  in  NUM_LANES*STAMP_W  stamps, lane 0 in LSBs
- write_enable  out  1;  write_uuid  out  UUID_WIDTH;  write_wid  out  NW_WIDTH;  write_tmask  out  NUM_LANES;  write_pid  out  PID_WIDTH;  write_data  out  NUM_LANES*STAMP_W  CSR store write port
- rsp_valid / rsp_ready  out/in  1  commit handshake
- rsp_uuid  out  UUID_WIDTH;  rsp_wid  out  NW_WIDTH;  rsp_tmask  out  NUM_THREADS (= req_tmask)
- rsp_data  out  NUM_THREADS  1 = thread received a stamp
- perf_stamps  out  32  count of stamps written to CSRs, wraps at 2^32

## Operation
- FSM: IDLE, FETCH, DRAIN, RSP.
- IDLE: req_ready=1. On req handshake, latch uuid/wid/tmask, pid=0, result=0, done_flag=0 -> FETCH.
- FETCH, per current pid, active = tmask[pid*NUM_LANES +: NUM_LANES]:
  - active==0: no handshake; advance pid in one cycle.
  - active!=0 and stamp_valid and !stamp_done: stamp_ready=1; on handshake, register a write beat (write_tmask = active & stamp_lmask, data, pid) and set result bits for those lanes; advance pid.
  - stamp_valid and stamp_done: stamp_ready=0, done_flag=1; all remaining pids produce no writes and result 0 -> DRAIN.
  - !stamp_valid: stall, pid held.
  - After the last pid advances -> DRAIN.
- stamp_ready = (state==FETCH) & (active!=0) & !stamp_done; it may depend combinationally on stamp_done only.
- DRAIN: one cycle, lets the final registered write pulse retire -> RSP.
- RSP: rsp_valid=1 with latched fields and result; hold stable until rsp_ready; on handshake -> IDLE.
- Lanes with active=1 but stamp_lmask=0 receive no write and result 0.
- perf_stamps += popcount(write_tmask) on each write_enable cycle.

## Timing
- Reset (async assert, sync deassert): state IDLE; req_ready=1 after reset; stamp_ready, write_enable, rsp_valid, write_*, rsp_*, perf_stamps all 0.
- Reset mid-operation aborts: no further writes, no response, latched request discarded.
- Write port registered: stamp handshake in cycle t -> write_enable=1 for exactly cycle t+1.
- Best case NUM_PIDS=1, stamp ready: req hs at t, stamp hs t+1, write t+2, DRAIN t+2, rsp_valid t+3.
- rsp_valid never asserts before the last write_enable pulse of the request has retired.
- At most one request in flight; req_ready=0 from the cycle after req handshake until the cycle after rsp handshake.
- Back-to-back stamp beats for consecutive pids are accepted on consecutive cycles.

## Test plan
- NUM_THREADS=4, NUM_LANES=4, tmask=1111, stamp lmask=1111 available -> one write pulse pid=0 tmask=1111 at t+2, rsp_valid at t+3, rsp_data=1111, perf_stamps=4.
- NUM_THREADS=8, NUM_LANES=4, tmask=0xF0 -> pid0 skipped with no stamp handshake, single write pid=1, rsp_data=0xF0.
- tmask=1111, stamp_lmask=0101 -> write_tmask=0101, rsp_data=0101, perf_stamps +2.
- NUM_THREADS=8, first beat valid, second beat stamp_done=1 -> one write pid=0, stamp_ready stays 0 on done beat, rsp_data=0x0F.
- stamp_valid low 5 cycles mid-request, rsp_ready low 3 cycles -> no write until beat arrives, rsp fields stable while stalled, req_ready=0 until rsp handshake.
- reset_n asserted while in FETCH -> all outputs 0 immediately, no rsp_valid after release, next request handled normally.
